combinational_to: RTL and testbench
===================================

COMBINATIONAL_TO -- requirements
Module: combinational_to

Interface
REQ-001 Parameter: WIDTH, default 6, number of one-hot state bits in X and Y; legal range 2..16.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  update enable; when 0 all registers hold.
REQ-005 X  input  WIDTH  current one-hot state code; bit i set means state Si.
REQ-006 Y  output  WIDTH  registered next-state code, one-hot.
REQ-007 err  output  1  registered flag; 1 means the last sampled X was not one-hot.
REQ-008 err_cnt  output  8  registered saturating count of non-one-hot samples.

Function
REQ-009 The block SHALL compute the next state of a WIDTH-state ring: Si -> S((i+1) mod WIDTH), a rotate-left by one of X.
REQ-010 Legal X (exactly one bit set) SHALL produce Y = rotl(X,1), so X=000001 gives Y=000010 and X=100000 gives Y=000001 (wrap-around).
REQ-011 Illegal X (zero bits set or two or more bits set) SHALL produce Y = S0 (bit 0 only) and err = 1.
REQ-012 Legal X SHALL produce err = 0.
REQ-013 Latency SHALL be exactly one clock: values sampled at edge k with en=1 appear on Y/err after edge k.
REQ-014 With en=0, Y, err and err_cnt SHALL hold their values and X SHALL be ignored.
REQ-015 err_cnt SHALL increment by 1 on each enabled edge where X is illegal, saturate at 255, and never wrap.
REQ-016 Outputs SHALL be glitch-free register outputs; no combinational path from X to any output.
REQ-017 The one-hot legality check SHALL be a pure combinational function of X: popcount(X) == 1.
REQ-018 No handshake; X is sampled unconditionally on every enabled edge.

Reset
REQ-019 While rst=1, Y SHALL be S0 (000001), err 0 and err_cnt 0, regardless of clk, en or X.
REQ-020 Reset assertion mid-operation SHALL take effect immediately, without waiting for a clock edge.
REQ-021 The first enabled edge after rst deasserts SHALL sample X normally.

Structure
REQ-022 A shared package SHALL hold the WIDTH default (6), the S0 constant and the err_cnt width (8) and saturation value (255).
REQ-023 One sub-module onehot_check SHALL take X and output the legal flag and the rotated code.
REQ-024 The top SHALL contain only the registers, the enable and the saturation logic.

Verification
REQ-025 Walk the single set bit in X through 000001, 000010, 000100, 001000, 010000, 100000 with en=1 -> Y one cycle later = 000010, 000100, 001000, 010000, 100000, 000001; err stays 0.
REQ-026 X=000000, then X=000011 -> Y=000001, err=1 each cycle, err_cnt=1 then 2; next X=000100 -> Y=001000, err=0, err_cnt stays 2.
REQ-027 Y=001000, then en=0 with X=000001 for 3 cycles -> Y stays 001000 and err_cnt is unchanged.
REQ-028 Apply 300 consecutive illegal samples (X=111111) -> err_cnt reaches 255 and holds at 255.
REQ-029 Assert rst between clock edges while Y=010000 and err_cnt=5 -> Y=000001, err=0, err_cnt=0 immediately; first edge after release with X=000010 -> Y=000100.

Source files
------------

// File: rtl/combinational_to_pkg.sv
// Shared constants for the one-hot ring next-state block.
// Holds the default ring size, the S0 code, and the error counter
// width and saturation value.
package combinational_to_pkg;

  // Default number of one-hot state bits (legal range 2..16).
  localparam int WIDTH_DEFAULT = 6;
  localparam int WIDTH_MAX     = 16;

  // S0 code at maximum width; callers truncate to their own WIDTH.
  localparam logic [WIDTH_MAX-1:0] S0_CODE = 16'h0001;

  // Saturating error counter.
  localparam int                  ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/combinational_to_onehot_check.sv
// onehot_check: purely combinational legality check and ring advance.
// Ports: x (state code in), legal (popcount(x) == 1), rot (x rotated left by one).
// No state and no clock; the parent registers the results.
module onehot_check
  import combinational_to_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] x,
  output logic             legal,
  output logic [WIDTH-1:0] rot
);

  // Five bits are enough to count up to 16 set bits.
  logic [4:0] ones;

  always_comb begin
    ones = 5'd0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + 5'(x[i]);
    end
    legal = (ones == 5'd1);
  end

  // Si -> S(i+1 mod WIDTH): the MSB wraps around into bit 0.
  assign rot = {x[WIDTH-2:0], x[WIDTH-1]};

endmodule

// File: rtl/combinational_to.sv
// combinational_to: registered next-state of a WIDTH-state one-hot ring.
// Ports: clk, rst (async, active-high), en (hold when low), X (current code),
//        Y (registered next code), err (last sample illegal), err_cnt (saturating count).
module combinational_to
  import combinational_to_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     X,
  output logic [WIDTH-1:0]     Y,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [WIDTH-1:0] S0 = WIDTH'(S0_CODE);

  logic             legal;
  logic [WIDTH-1:0] rot;

  onehot_check #(.WIDTH(WIDTH)) u_onehot_check (
    .x     (X),
    .legal (legal),
    .rot   (rot)
  );

  logic [WIDTH-1:0]     y_d,       y_q;
  logic                 err_d,     err_q;
  logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

  always_comb begin
    y_d       = y_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (en) begin
      // Illegal codes recover the ring to S0 rather than propagating garbage.
      y_d   = legal ? rot : S0;
      err_d = ~legal;
      if (!legal && (err_cnt_q != ERR_CNT_MAX)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q       <= S0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      y_q       <= y_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Outputs come straight from flops: no combinational path from X.
  assign Y       = y_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_combinational_to.sv
module tb_combinational_to;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic [W-1:0] x   = '0;
  logic [W-1:0] y;
  logic         err;
  logic [7:0]   err_cnt;

  combinational_to #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .X       (x),
    .Y       (y),
    .err     (err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic [W-1:0] x;
    logic [W-1:0] ey;
    logic         eerr;
    logic [7:0]   ecnt;
  } vec_t;

  typedef struct {
    logic [W-1:0] ey;
    logic         eerr;
    logic [7:0]   ecnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive on the falling edge, push the expectation, compare 1 time unit after the rising edge.
  task automatic step(input logic e, input logic [W-1:0] xi,
                      input logic [W-1:0] ey, input logic eerr, input logic [7:0] ecnt,
                      input string name);
    exp_t ex;
    @(negedge clk);
    en = e;
    x  = xi;
    ex.ey = ey; ex.eerr = eerr; ex.ecnt = ecnt;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 16'd1, 16'd0);
    end else begin
      ex = sb.pop_front();
      check({name, "_y"},   16'(y),       16'(ex.ey));
      check({name, "_err"}, 16'(err),     16'(ex.eerr));
      check({name, "_cnt"}, 16'(err_cnt), 16'(ex.ecnt));
    end
  endtask

  vec_t vecs[$];
  logic [7:0] mcnt;

  initial begin
    // Walk, illegal codes, hold, then build up err_cnt=5 with Y=010000.
    vecs = '{
      '{1'b1, 6'b000001, 6'b000010, 1'b0, 8'd0},
      '{1'b1, 6'b000010, 6'b000100, 1'b0, 8'd0},
      '{1'b1, 6'b000100, 6'b001000, 1'b0, 8'd0},
      '{1'b1, 6'b001000, 6'b010000, 1'b0, 8'd0},
      '{1'b1, 6'b010000, 6'b100000, 1'b0, 8'd0},
      '{1'b1, 6'b100000, 6'b000001, 1'b0, 8'd0},
      '{1'b1, 6'b000000, 6'b000001, 1'b1, 8'd1},
      '{1'b1, 6'b000011, 6'b000001, 1'b1, 8'd2},
      '{1'b1, 6'b000100, 6'b001000, 1'b0, 8'd2},
      '{1'b0, 6'b000001, 6'b001000, 1'b0, 8'd2},
      '{1'b0, 6'b000001, 6'b001000, 1'b0, 8'd2},
      '{1'b0, 6'b000001, 6'b001000, 1'b0, 8'd2},
      '{1'b0, 6'b111111, 6'b001000, 1'b0, 8'd2},
      '{1'b1, 6'b101000, 6'b000001, 1'b1, 8'd3},
      '{1'b1, 6'b111111, 6'b000001, 1'b1, 8'd4},
      '{1'b0, 6'b000100, 6'b000001, 1'b1, 8'd4},
      '{1'b1, 6'b110000, 6'b000001, 1'b1, 8'd5},
      '{1'b1, 6'b001000, 6'b010000, 1'b0, 8'd5}
    };

    // Reset held across clock edges with en=1: outputs stay at reset values.
    en = 1'b1;
    x  = 6'b000100;
    repeat (2) @(posedge clk);
    #1;
    check("rst_y",   16'(y),       16'h0001);
    check("rst_err", 16'(err),     16'h0000);
    check("rst_cnt", 16'(err_cnt), 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].x, vecs[i].ey, vecs[i].eerr, vecs[i].ecnt,
           $sformatf("vec%0d", i));
    end

    // Asynchronous reset between edges while Y=010000, err_cnt=5.
    #2;
    rst = 1'b1;
    #1;
    check("arst_y",   16'(y),       16'h0001);
    check("arst_err", 16'(err),     16'h0000);
    check("arst_cnt", 16'(err_cnt), 16'h0000);
    #1;
    rst = 1'b0;
    step(1'b1, 6'b000010, 6'b000100, 1'b0, 8'd0, "post_rst");

    // Saturation: 300 consecutive illegal samples; model count independently.
    mcnt = 8'd0;
    for (int k = 0; k < 300; k++) begin
      mcnt = (mcnt == 8'hFF) ? 8'hFF : mcnt + 8'd1;
      step(1'b1, 6'b111111, 6'b000001, 1'b1, mcnt, $sformatf("sat%0d", k));
    end
    check("sat_final", 16'(err_cnt), 16'd255);
    // Legal sample after saturation: err clears, count holds.
    step(1'b1, 6'b100000, 6'b000001, 1'b0, 8'd255, "sat_legal");
    step(1'b1, 6'b000001, 6'b000010, 1'b0, 8'd255, "sat_legal2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
